// File: rtl/cameralink_tx_timing_if.sv
// Upstream FIFO read port and Camera Link output bus of the TX timing generator.
// master = timing generator, slave = FIFO/serializer side.
interface cameralink_tx_timing_if #(parameter int DW = 16);
   logic [15:0]   fifo_rd_count;
   logic          fifo_rden;
   logic [DW-1:0] fifo_dout;
   logic          cm_frame_valid;
   logic          cm_line_valid;
   logic          cm_data_valid;
   logic [DW-1:0] cm_dout;

   modport master (
      input  fifo_rd_count, fifo_dout,
      output fifo_rden, cm_frame_valid, cm_line_valid, cm_data_valid, cm_dout
   );

   modport slave (
      output fifo_rd_count, fifo_dout,
      input  fifo_rden, cm_frame_valid, cm_line_valid, cm_data_valid, cm_dout
   );
endinterface

// File: rtl/cameralink_tx_timing.sv
// Camera Link transmit timing generator: pulls whole lines from a 1-cycle-latency FIFO
// and emits FVAL/LVAL/DVAL/data with programmable image size and blanking.
module cameralink_tx_timing #(
   parameter int DW       = 16,
   parameter int H_BLANK  = 16,
   parameter int V_BLANK  = 64,
   parameter int FV_LEAD  = 4,
   parameter int FV_TRAIL = 4
) (
   input  logic        cm_data_clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] app_image_w,
   input  logic [15:0] app_image_h,
   output logic        frame_done,
   output logic        busy,
   cameralink_tx_timing_if.master bus
);
   // FIFO read latency (1) plus output register (1): rden at k -> LVAL at k+2.
   localparam int ALIGN = 2;
   localparam logic [15:0] LEAD_LAST  = 16'((FV_LEAD > 1) ? FV_LEAD - 2 : 0);
   localparam logic [15:0] HBLK_LAST  = 16'(H_BLANK - 1);
   localparam logic [15:0] TRAIL_LAST = 16'(FV_TRAIL - 1);
   localparam logic [15:0] VBLK_LAST  = 16'(V_BLANK - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEAD, S_WAIT, S_LINE, S_HBLK, S_TRAIL, S_VBLK
   } state_t;

   typedef struct packed {
      logic fv;
      logic lv;
   } cm_ctl_t;

   state_t             state;
   logic [15:0]        w_lat, h_lat;
   logic [15:0]        pix_cnt, line_cnt, cnt;
   logic               fv_int, rden;
   cm_ctl_t [ALIGN:1]  vld_pipe;
   logic [DW-1:0]      dout_q;
   logic               start_ok;

   assign start_ok = enable && (app_image_w != '0) && (app_image_h != '0);

   always_ff @(posedge cm_data_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         w_lat    <= '0;
         h_lat    <= '0;
         pix_cnt  <= '0;
         line_cnt <= '0;
         cnt      <= '0;
         fv_int   <= 1'b0;
         rden     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  w_lat    <= app_image_w;
                  h_lat    <= app_image_h;
                  line_cnt <= '0;
                  cnt      <= '0;
                  fv_int   <= 1'b1;
                  busy     <= 1'b1;
                  state    <= (FV_LEAD > 1) ? S_LEAD : S_WAIT;
               end
            end
            S_LEAD: begin
               if (cnt == LEAD_LAST) begin
                  cnt   <= '0;
                  state <= S_WAIT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            // A line only starts once the whole line is buffered upstream.
            S_WAIT: begin
               if (bus.fifo_rd_count >= w_lat) begin
                  rden    <= 1'b1;
                  pix_cnt <= '0;
                  state   <= S_LINE;
               end
            end
            S_LINE: begin
               if (pix_cnt == w_lat - 16'd1) begin
                  rden     <= 1'b0;
                  cnt      <= '0;
                  line_cnt <= line_cnt + 16'd1;
                  state    <= (line_cnt == h_lat - 16'd1) ? S_TRAIL : S_HBLK;
               end else begin
                  pix_cnt <= pix_cnt + 16'd1;
               end
            end
            S_HBLK: begin
               if (cnt == HBLK_LAST) begin
                  cnt   <= '0;
                  state <= S_WAIT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_TRAIL: begin
               if (cnt == TRAIL_LAST) begin
                  cnt    <= '0;
                  fv_int <= 1'b0;
                  state  <= S_VBLK;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_VBLK: begin
               if (cnt == VBLK_LAST) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FVAL/LVAL ride the same pipe so their relative timing is preserved exactly.
   always_ff @(posedge cm_data_clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe   <= '0;
         dout_q     <= '0;
         frame_done <= 1'b0;
      end else begin
         vld_pipe[1] <= cm_ctl_t'{fv: fv_int, lv: rden};
         for (int i = 2; i <= ALIGN; i++) vld_pipe[i] <= vld_pipe[i-1];
         dout_q     <= vld_pipe[ALIGN-1].lv ? bus.fifo_dout : '0;
         frame_done <= vld_pipe[ALIGN].fv & ~vld_pipe[ALIGN-1].fv;
      end
   end

   assign bus.fifo_rden      = rden;
   assign bus.cm_frame_valid = vld_pipe[ALIGN].fv;
   assign bus.cm_line_valid  = vld_pipe[ALIGN].lv;
   assign bus.cm_data_valid  = vld_pipe[ALIGN].lv;
   assign bus.cm_dout        = dout_q;

endmodule
